decode_control_stage: RTL and testbench
=======================================

// Module: decode_control_stage
// PURPOSE
//  Parametrised successor of the combinational decode control unit. Decodes the
//  MIPS subset below and registers all control signals into the ID/EX control register.
//  Adds load-use hazard detection with bubble insertion, branch flush and HALT state.
//  Keeps a saturating stall-bubble counter.
//  Sits in the decode stage, between the IF/ID register and the execute stage.
// PARAMETERS
//  NB            32   instruction width
//  NB_REGS       5    register-address width
//  NB_OPCODE     6    opcode/funct width
//  NB_SIZE_TYPE  3    o_word_size width
//  NB_CNT        16   bubble-counter width
//  LINK_REG      31   destination register for JAL
// PORTS
//  i_clk              in   1            clock, rising edge
//  i_reset            in   1            synchronous, active-high reset
//  i_instruction      in   NB           instruction from IF/ID
//  i_valid            in   1            i_instruction is valid
//  i_flush            in   1            taken branch/jump: squash the instruction now in decode
//  o_stall            out  1            combinational: hold PC and IF/ID this cycle
//  o_valid            out  1            registered: the control word is a real instruction
//  o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write,
//  o_branch, o_branch_ne, o_jump, o_jump_reg, o_link, o_signed,
//  o_halt, o_illegal
//                     out  1 each       registered control bits
//  o_reg_dir_to_write out  NB_REGS      registered destination register
//  o_ExtensionMode    out  2            SIGNED / UNSIGNED / LUI extension-mode macros
//  o_word_size        out  NB_SIZE_TYPE BYTE / HALF / COMPLETE word macros
//  o_bubble_count     out  NB_CNT       stall bubbles inserted since reset
// BEHAVIOUR
//  Reset: all outputs are 0 except o_word_size=`COMPLETE_WORD. State=RUN. Counter=0.
//  Latency: 1 cycle. A word decoded at edge N drives the outputs from edge N until edge N+1.
//  Bubble: o_valid=0, all control bits 0, o_word_size=`COMPLETE_WORD, o_reg_dir_to_write=0.
//  Next-register priority: reset > HALTED > i_flush > o_stall > !i_valid (bubble) > decode.
//  Decode (opcode [31:26]):
//   R 000000 -> rd, RT src, reg_write. Exception: funct 001000 (JR) -> o_jump_reg=1, no write.
//   ADDI 001000 and SLTI 001010 -> rt, IMM src, SIGNED extension.
//   ANDI 001100, ORI 001101, XORI 001110 -> rt, IMM src, UNSIGNED extension.
//   LUI 001111 -> rt, IMM src, LUI extension.
//   BEQ 000100 / BNE 000101 -> o_branch=1 (o_branch_ne=1 for BNE), RT src, SIGNED, no write.
//   J 000010 -> o_jump=1. JAL 000011 -> o_jump, o_link, reg_write, dest=LINK_REG.
//   LB 100000, LH 100001, LW 100011 -> mem_read, mem_to_reg, reg_write to rt, o_signed=1.
//   LBU 100100, LHU 100101 -> same as the signed loads with o_signed=0. Word size BYTE/HALF/COMPLETE.
//   SB 101000, SH 101001, SW 101011 -> mem_write, IMM src, SIGNED extension, size BYTE/HALF/COMPLETE.
//   HALT 111111 -> o_valid=1, o_halt=1, other bits 0. State -> HALTED.
//   Any other opcode -> o_valid=1, o_illegal=1, other bits 0. One-cycle flag; no state change.
//  Destination register 0: o_reg_write is forced to 0 (covers NOP 0x00000000).
//  o_stall=1 when all of the following hold:
//   - state=RUN, i_valid=1, i_flush=0;
//   - the registered word is valid, has o_mem_read=1 and o_reg_dir_to_write=d, with d!=0;
//   - the current instruction reads d: rs is read by every instruction except J/JAL/LUI;
//     rt is read by R-type, BEQ/BNE and stores.
//  During o_stall the next edge registers a bubble and the counter increments.
//  The counter saturates at all-ones. Flush bubbles are not counted.
//  HALTED: outputs are bubbles with o_halt held at 1. o_stall=1 permanently.
//  i_flush is ignored in HALTED. Only i_reset leaves HALTED.
//  Reset mid-stall or mid-HALT: the outputs show the reset values at the next edge.
// TESTING
//  Reset, then hold i_reset=1 for 3 cycles -> all outputs 0, o_word_size=COMPLETE, o_bubble_count=0.
//  LW r2,0(r1) then ADD r3,r2,r4 -> o_stall=1 for exactly 1 cycle; 1 bubble;
//    ADD appears 2 cycles after LW; o_bubble_count=1.
//  LW r2 then ADDI r5,r0,7 (no dependency) -> o_stall stays 0; back-to-back outputs.
//  LW r0,0(r1) then ADD r3,r0,r0 -> no stall; LW shows o_reg_write=0.
//  BEQ then i_flush=1 together with LW r2 / ADD r2 -> bubble registered; o_stall=0; counter unchanged.
//  LB/LHU/SH/JAL/JR/LUI/unknown opcode 0x3B -> exact control fields per the decode table.
//    JAL: dest=31. 0x3B: o_illegal=1 for 1 cycle.
//  HALT, then ADD -> o_halt=1 and o_stall=1 forever, ADD is never issued; i_reset returns state to RUN.

Source files
------------

// File: rtl/decode_control_stage_if.sv
// Decode-stage bus: instruction in from IF/ID, registered ID/EX control word out.
// Also defines the extension-mode and word-size encodings shared by the stage.
`ifndef DECODE_CONTROL_STAGE_MACROS
`define DECODE_CONTROL_STAGE_MACROS
`define SIGNED_EXTENSION   2'b00
`define UNSIGNED_EXTENSION 2'b01
`define LUI_EXTENSION      2'b10
`define BYTE_WORD          3'b001
`define HALF_WORD          3'b010
`define COMPLETE_WORD      3'b100
`endif

interface decode_control_stage_if #(
    parameter int NB           = 32,
    parameter int NB_REGS      = 5,
    parameter int NB_SIZE_TYPE = 3,
    parameter int NB_CNT       = 16
);
    logic [NB-1:0]           i_instruction;
    logic                    i_valid;
    logic                    i_flush;
    logic                    o_stall;
    logic                    o_valid;
    logic                    o_ALUSrc;
    logic                    o_mem_read;
    logic                    o_mem_write;
    logic                    o_mem_to_reg;
    logic                    o_reg_write;
    logic                    o_branch;
    logic                    o_branch_ne;
    logic                    o_jump;
    logic                    o_jump_reg;
    logic                    o_link;
    logic                    o_signed;
    logic                    o_halt;
    logic                    o_illegal;
    logic [NB_REGS-1:0]      o_reg_dir_to_write;
    logic [1:0]              o_ExtensionMode;
    logic [NB_SIZE_TYPE-1:0] o_word_size;
    logic [NB_CNT-1:0]       o_bubble_count;

    modport master (
        output i_instruction, i_valid, i_flush,
        input  o_stall, o_valid, o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg,
               o_reg_write, o_branch, o_branch_ne, o_jump, o_jump_reg, o_link,
               o_signed, o_halt, o_illegal, o_reg_dir_to_write, o_ExtensionMode,
               o_word_size, o_bubble_count
    );

    modport slave (
        input  i_instruction, i_valid, i_flush,
        output o_stall, o_valid, o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg,
               o_reg_write, o_branch, o_branch_ne, o_jump, o_jump_reg, o_link,
               o_signed, o_halt, o_illegal, o_reg_dir_to_write, o_ExtensionMode,
               o_word_size, o_bubble_count
    );
endinterface

// File: rtl/decode_control_stage.sv
// MIPS-subset decode stage: registers the ID/EX control word, inserts load-use
// bubbles, squashes on flush and parks in a sticky HALTED state.
module decode_control_stage #(
    parameter int NB           = 32,
    parameter int NB_REGS      = 5,
    parameter int NB_OPCODE    = 6,
    parameter int NB_SIZE_TYPE = 3,
    parameter int NB_CNT       = 16,
    parameter int LINK_REG     = 31
) (
    input logic                   i_clk,
    input logic                   i_reset,
    decode_control_stage_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic                    valid;
        logic                    alu_src;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    branch;
        logic                    branch_ne;
        logic                    jump;
        logic                    jump_reg;
        logic                    link;
        logic                    sgn;
        logic                    halt;
        logic                    illegal;
        logic [NB_REGS-1:0]      dest;
        logic [1:0]              ext;
        logic [NB_SIZE_TYPE-1:0] size;
    } ctrl_t;

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000,
        OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
        OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_BEQ = 6'b000100,
        OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011,
        OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011,
        OP_LBU = 6'b100100, OP_LHU = 6'b100101, OP_SB = 6'b101000,
        OP_SH = 6'b101001, OP_SW = 6'b101011, OP_HALT = 6'b111111;
    localparam logic [NB_OPCODE-1:0] FN_JR = 6'b001000;

    function automatic ctrl_t bubble_word(input logic halt);
        ctrl_t w;
        w      = '0;
        w.size = NB_SIZE_TYPE'(`COMPLETE_WORD);
        w.halt = halt;
        return w;
    endfunction

    // Memory access width is carried in the low two opcode bits of loads and stores.
    function automatic logic [NB_SIZE_TYPE-1:0] access_size(input logic [1:0] sel);
        case (sel)
            2'b00:   return NB_SIZE_TYPE'(`BYTE_WORD);
            2'b01:   return NB_SIZE_TYPE'(`HALF_WORD);
            default: return NB_SIZE_TYPE'(`COMPLETE_WORD);
        endcase
    endfunction

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              state;
    ctrl_t               ctrl_p1;
    logic [NB_CNT-1:0]   bubble_cnt_p1;
    ctrl_t               dec;
    logic                reads_rs;
    logic                reads_rt;
    logic                load_use;
    logic                stall;

    logic [NB_OPCODE-1:0] opcode;
    logic [NB_OPCODE-1:0] funct;
    logic [NB_REGS-1:0]   rs;
    logic [NB_REGS-1:0]   rt;
    logic [NB_REGS-1:0]   rd;
    logic                 unused_shamt;

    assign opcode       = bus.i_instruction[NB-1 -: NB_OPCODE];
    assign rs           = bus.i_instruction[21 +: NB_REGS];
    assign rt           = bus.i_instruction[16 +: NB_REGS];
    assign rd           = bus.i_instruction[11 +: NB_REGS];
    assign funct        = bus.i_instruction[0 +: NB_OPCODE];
    assign unused_shamt = ^bus.i_instruction[10:6];

    always_comb begin
        dec       = bubble_word(1'b0);
        dec.valid = 1'b1;
        reads_rs  = 1'b1;
        reads_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                if (funct == FN_JR) begin
                    dec.jump_reg = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.dest      = rd;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = rt;
                if (opcode == OP_LUI) begin
                    dec.ext  = `LUI_EXTENSION;
                    reads_rs = 1'b0;
                end else if (opcode == OP_ADDI || opcode == OP_SLTI) begin
                    dec.ext = `SIGNED_EXTENSION;
                end else begin
                    dec.ext = `UNSIGNED_EXTENSION;
                end
            end
            OP_BEQ, OP_BNE: begin
                dec.branch    = 1'b1;
                dec.branch_ne = (opcode == OP_BNE);
                reads_rt      = 1'b1;
            end
            OP_J: begin
                dec.jump = 1'b1;
                reads_rs = 1'b0;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = NB_REGS'(LINK_REG);
                reads_rs      = 1'b0;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.dest       = rt;
                dec.sgn        = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
                dec.size       = access_size(opcode[1:0]);
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.size      = access_size(opcode[1:0]);
                reads_rt      = 1'b1;
            end
            OP_HALT:  dec.halt    = 1'b1;
            default:  dec.illegal = 1'b1;
        endcase
        // Writes to r0 are architecturally discarded; this also makes 0x00000000 a NOP.
        if (dec.dest == '0) dec.reg_write = 1'b0;
    end

    assign load_use = ctrl_p1.valid && ctrl_p1.mem_read && (ctrl_p1.dest != '0) &&
                      ((reads_rs && (rs == ctrl_p1.dest)) || (reads_rt && (rt == ctrl_p1.dest)));
    assign stall    = (state == HALTED) || (bus.i_valid && !bus.i_flush && load_use);

    // ---- ID/EX control register (p1) ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= RUN;
            ctrl_p1       <= bubble_word(1'b0);
            bubble_cnt_p1 <= '0;
        end else if (state == HALTED) begin
            ctrl_p1 <= bubble_word(1'b1);
        end else if (bus.i_flush) begin
            ctrl_p1 <= bubble_word(1'b0);
        end else if (stall) begin
            ctrl_p1       <= bubble_word(1'b0);
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end else if (!bus.i_valid) begin
            ctrl_p1 <= bubble_word(1'b0);
        end else begin
            ctrl_p1 <= dec;
            if (dec.halt) state <= HALTED;
        end
    end

    assign bus.o_stall            = stall;
    assign bus.o_valid            = ctrl_p1.valid;
    assign bus.o_ALUSrc           = ctrl_p1.alu_src;
    assign bus.o_mem_read         = ctrl_p1.mem_read;
    assign bus.o_mem_write        = ctrl_p1.mem_write;
    assign bus.o_mem_to_reg       = ctrl_p1.mem_to_reg;
    assign bus.o_reg_write        = ctrl_p1.reg_write;
    assign bus.o_branch           = ctrl_p1.branch;
    assign bus.o_branch_ne        = ctrl_p1.branch_ne;
    assign bus.o_jump             = ctrl_p1.jump;
    assign bus.o_jump_reg         = ctrl_p1.jump_reg;
    assign bus.o_link             = ctrl_p1.link;
    assign bus.o_signed           = ctrl_p1.sgn;
    assign bus.o_halt             = ctrl_p1.halt;
    assign bus.o_illegal          = ctrl_p1.illegal;
    assign bus.o_reg_dir_to_write = ctrl_p1.dest;
    assign bus.o_ExtensionMode    = ctrl_p1.ext;
    assign bus.o_word_size        = ctrl_p1.size;
    assign bus.o_bubble_count     = bubble_cnt_p1;
endmodule

// File: tb/tb_decode_control_stage.sv
// Bench for decode_control_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_decode_control_stage;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [1:0] EXT_S = 2'b00, EXT_U = 2'b01, EXT_LUI = 2'b10;
    localparam logic [2:0] SZ_B = 3'b001, SZ_H = 3'b010, SZ_W = 3'b100;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
        OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_BEQ = 6'h04, OP_BNE = 6'h05,
        OP_J = 6'h02, OP_JAL = 6'h03, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
        OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B,
        OP_HALT = 6'h3F, OP_ILL = 6'h3B;

    localparam logic [5:0] RAND_OPS [21] = '{OP_R, OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
        OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW, OP_ILL};

    typedef struct packed {
        logic       valid;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       sgn;
        logic       halt;
        logic       illegal;
        logic [4:0] dest;
        logic [1:0] ext;
        logic [2:0] size;
    } cw_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_control_stage_if #(.NB_CNT(CNT_W)) bus();
    decode_control_stage #(.NB_CNT(CNT_W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    int  n_tests = 0;
    int  n_fail  = 0;
    cw_t m_prev;
    bit  m_halted;
    int  m_cnt;
    bit  st_obs;
    bit  st_exp;

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic cw_t bubble(input bit halt);
        cw_t w;
        w      = '0;
        w.size = SZ_W;
        w.halt = halt;
        return w;
    endfunction

    // Expected control word for one issued instruction, straight from the decode table.
    function automatic cw_t ref_decode(input logic [31:0] ins);
        cw_t        w;
        logic [5:0] op;
        logic [4:0] rt;
        op      = ins[31:26];
        rt      = ins[20:16];
        w       = bubble(1'b0);
        w.valid = 1'b1;
        case (op)
            OP_R: if (ins[5:0] == 6'h08) w.jump_reg = 1'b1;
                  else begin w.dest = ins[15:11]; w.reg_write = (ins[15:11] != 0); end
            OP_ADDI, OP_SLTI: begin w.dest = rt; w.alu_src = 1; w.ext = EXT_S; w.reg_write = (rt != 0); end
            OP_ANDI, OP_ORI, OP_XORI: begin w.dest = rt; w.alu_src = 1; w.ext = EXT_U; w.reg_write = (rt != 0); end
            OP_LUI: begin w.dest = rt; w.alu_src = 1; w.ext = EXT_LUI; w.reg_write = (rt != 0); end
            OP_BEQ: w.branch = 1'b1;
            OP_BNE: begin w.branch = 1'b1; w.branch_ne = 1'b1; end
            OP_J:   w.jump = 1'b1;
            OP_JAL: begin w.jump = 1; w.link = 1; w.reg_write = 1; w.dest = 5'd31; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                w.mem_read = 1; w.mem_to_reg = 1; w.alu_src = 1; w.dest = rt; w.reg_write = (rt != 0);
                w.sgn  = (op == OP_LB || op == OP_LH || op == OP_LW);
                w.size = (op == OP_LB || op == OP_LBU) ? SZ_B : (op == OP_LW) ? SZ_W : SZ_H;
            end
            OP_SB:   begin w.mem_write = 1; w.alu_src = 1; w.size = SZ_B; end
            OP_SH:   begin w.mem_write = 1; w.alu_src = 1; w.size = SZ_H; end
            OP_SW:   begin w.mem_write = 1; w.alu_src = 1; w.size = SZ_W; end
            OP_HALT: w.halt = 1'b1;
            default: w.illegal = 1'b1;
        endcase
        return w;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] op;
        bit         uses_rs;
        bit         uses_rt;
        op      = ins[31:26];
        uses_rs = !(op == OP_J || op == OP_JAL || op == OP_LUI);
        uses_rt = (op == OP_R || op == OP_BEQ || op == OP_BNE || op == OP_SB || op == OP_SH || op == OP_SW);
        return (uses_rs && ins[25:21] == r) || (uses_rt && ins[20:16] == r);
    endfunction

    function automatic bit model_stall(input logic [31:0] ins, input bit v, input bit f);
        if (m_halted) return 1'b1;
        return v && !f && m_prev.valid && m_prev.mem_read && m_prev.dest != 0 && reads_reg(ins, m_prev.dest);
    endfunction

    function automatic cw_t obs_word();
        cw_t w;
        w.valid = bus.o_valid;           w.alu_src = bus.o_ALUSrc;
        w.mem_read = bus.o_mem_read;     w.mem_write = bus.o_mem_write;
        w.mem_to_reg = bus.o_mem_to_reg; w.reg_write = bus.o_reg_write;
        w.branch = bus.o_branch;         w.branch_ne = bus.o_branch_ne;
        w.jump = bus.o_jump;             w.jump_reg = bus.o_jump_reg;
        w.link = bus.o_link;             w.sgn = bus.o_signed;
        w.halt = bus.o_halt;             w.illegal = bus.o_illegal;
        w.dest = bus.o_reg_dir_to_write; w.ext = bus.o_ExtensionMode;
        w.size = bus.o_word_size;
        return w;
    endfunction

    // Drive one decode cycle, capture o_stall before the edge, advance the model past it.
    task automatic cycle(input logic [31:0] ins, input bit v, input bit f, input bit r);
        @(negedge clk);
        bus.i_instruction = ins;
        bus.i_valid       = v;
        bus.i_flush       = f;
        rst               = r;
        #1;
        st_obs = bus.o_stall;
        st_exp = model_stall(ins, v, f);
        if (r) begin
            m_prev = bubble(1'b0); m_halted = 1'b0; m_cnt = 0;
        end else if (m_halted) begin
            m_prev = bubble(1'b1);
        end else if (f) begin
            m_prev = bubble(1'b0);
        end else if (st_exp) begin
            m_prev = bubble(1'b0);
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (!v) begin
            m_prev = bubble(1'b0);
        end else begin
            m_prev = ref_decode(ins);
            if (ins[31:26] == OP_HALT) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs_word() !== bubble(1'b0)) begin
            n_fail++; $display("FAIL reset_word: got %h want %h", obs_word(), bubble(1'b0));
        end
        n_tests++;
        if (bus.o_bubble_count !== 4'd0 || bus.o_word_size !== SZ_W) begin
            n_fail++; $display("FAIL reset_cnt_size: got cnt %0d size %b want 0 / %b", bus.o_bubble_count, bus.o_word_size, SZ_W);
        end
        n_tests++;
        if (st_obs !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", st_obs);
        end
    endtask

    task automatic test_load_use();
        cycle(32'h0, 1'b1, 1'b0, 1'b0);
        cycle(i_ins(OP_LW, 1, 2, 0), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_word() !== m_prev || bus.o_reg_dir_to_write !== 5'd2 || bus.o_mem_read !== 1'b1) begin
            n_fail++; $display("FAIL lw_word: got %h want %h", obs_word(), m_prev);
        end
        cycle(r_ins(2, 4, 3, 6'h20), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (st_obs !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_bubble_count !== 4'd1) begin
            n_fail++; $display("FAIL load_use_stall: got stall %b valid %b cnt %0d want 1 0 1", st_obs, bus.o_valid, bus.o_bubble_count);
        end
        cycle(r_ins(2, 4, 3, 6'h20), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (st_obs !== 1'b0 || obs_word() !== ref_decode(r_ins(2, 4, 3, 6'h20)) || bus.o_reg_dir_to_write !== 5'd3) begin
            n_fail++; $display("FAIL load_use_issue: got stall %b word %h want 0 %h", st_obs, obs_word(), ref_decode(r_ins(2, 4, 3, 6'h20)));
        end
    endtask

    task automatic test_reset_mid_stall();
        cycle(i_ins(OP_LW, 1, 2, 0), 1'b1, 1'b0, 1'b0);
        cycle(r_ins(2, 4, 3, 6'h20), 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (st_obs !== 1'b1 || obs_word() !== bubble(1'b0) || bus.o_bubble_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_stall: got stall %b word %h cnt %0d want 1 %h 0", st_obs, obs_word(), bus.o_bubble_count, bubble(1'b0));
        end
    endtask

    task automatic test_no_dependency();
        cycle(i_ins(OP_LW, 1, 2, 0), 1'b1, 1'b0, 1'b0);
        cycle(i_ins(OP_ADDI, 0, 5, 7), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (st_obs !== 1'b0 || obs_word() !== ref_decode(i_ins(OP_ADDI, 0, 5, 7)) || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL no_dep: got stall %b word %h want 0 %h", st_obs, obs_word(), ref_decode(i_ins(OP_ADDI, 0, 5, 7)));
        end
    endtask

    task automatic test_dest_r0();
        cycle(i_ins(OP_LW, 1, 0, 0), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_reg_write !== 1'b0 || bus.o_mem_read !== 1'b1 || obs_word() !== m_prev) begin
            n_fail++; $display("FAIL lw_r0: got %h want %h", obs_word(), m_prev);
        end
        cycle(r_ins(0, 0, 3, 6'h20), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (st_obs !== 1'b0 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL r0_no_stall: got stall %b valid %b want 0 1", st_obs, bus.o_valid);
        end
    endtask

    task automatic test_flush();
        int cnt_before;
        cycle(i_ins(OP_BEQ, 1, 6, 4), 1'b1, 1'b0, 1'b0);
        cycle(i_ins(OP_LW, 1, 2, 0), 1'b1, 1'b0, 1'b0);
        cnt_before = int'(bus.o_bubble_count);
        cycle(r_ins(2, 2, 3, 6'h20), 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (st_obs !== 1'b0 || obs_word() !== bubble(1'b0) || int'(bus.o_bubble_count) != cnt_before) begin
            n_fail++; $display("FAIL flush: got stall %b word %h cnt %0d want 0 %h %0d", st_obs, obs_word(), bus.o_bubble_count, bubble(1'b0), cnt_before);
        end
    endtask

    task automatic test_decode_table();
        logic [31:0] list [7];
        list = '{i_ins(OP_LB, 3, 4, 8), i_ins(OP_LHU, 3, 5, 2), i_ins(OP_SH, 3, 6, 4),
                 {OP_JAL, 26'h123}, r_ins(7, 0, 0, 6'h08), i_ins(OP_LUI, 0, 9, 16'h1234),
                 {OP_ILL, 26'h0}};
        foreach (list[k]) begin
            cycle(32'h0, 1'b0, 1'b0, 1'b0);
            cycle(list[k], 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_word() !== m_prev) begin
                n_fail++; $display("FAIL decode_%0d: got %h want %h", k, obs_word(), m_prev);
            end
        end
        n_tests++;
        if (bus.o_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_flag: got %b want 1", bus.o_illegal);
        end
        cycle(32'h0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_illegal !== 1'b0 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL illegal_one_cycle: got illegal %b valid %b want 0 1", bus.o_illegal, bus.o_valid);
        end
        cycle({OP_JAL, 26'h40}, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_reg_dir_to_write !== 5'd31 || bus.o_link !== 1'b1 || bus.o_reg_write !== 1'b1) begin
            n_fail++; $display("FAIL jal_dest: got dest %0d link %b want 31 1", bus.o_reg_dir_to_write, bus.o_link);
        end
    endtask

    task automatic test_counter_saturation();
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(i_ins(OP_LW, 2, 2, 0), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_bubble_count !== 4'(CNT_MAX) || int'(bus.o_bubble_count) != m_cnt) begin
            n_fail++; $display("FAIL saturation: got %0d want %0d", bus.o_bubble_count, CNT_MAX);
        end
    endtask

    task automatic test_halt();
        bit ok;
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        cycle({OP_HALT, 26'h0}, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_halt !== 1'b1 || bus.o_valid !== 1'b1 || obs_word() !== m_prev) begin
            n_fail++; $display("FAIL halt_word: got %h want %h", obs_word(), m_prev);
        end
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(r_ins(1, 4, 3, 6'h20), 1'b1, i[0], 1'b0);
            if (st_obs !== 1'b1 || bus.o_halt !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_reg_write !== 1'b0) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL halted_hold: got stall %b halt %b valid %b want 1 1 0", st_obs, bus.o_halt, bus.o_valid);
        end
        cycle(r_ins(1, 4, 3, 6'h20), 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (obs_word() !== bubble(1'b0)) begin
            n_fail++; $display("FAIL halt_reset: got %h want %h", obs_word(), bubble(1'b0));
        end
        cycle(r_ins(1, 4, 3, 6'h20), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (st_obs !== 1'b0 || obs_word() !== ref_decode(r_ins(1, 4, 3, 6'h20))) begin
            n_fail++; $display("FAIL run_after_halt: got stall %b word %h want 0 %h", st_obs, obs_word(), ref_decode(r_ins(1, 4, 3, 6'h20)));
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
        bit          v;
        bit          f;
        bit          r;
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            op = RAND_OPS[$urandom_range(0, 20)];
            case ($urandom_range(0, 2))
                0:       fn = 6'h20;
                1:       fn = 6'h22;
                default: fn = 6'h08;
            endcase
            if (op == OP_R) ins = r_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), fn);
            else            ins = i_ins(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 79) == 0);
            cycle(ins, v, f, r);
            n_tests++;
            if (st_obs !== st_exp) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b ins %h", i, st_obs, st_exp, ins);
            end
            n_tests++;
            if (obs_word() !== m_prev) begin
                n_fail++; $display("FAIL rand_word[%0d]: got %h want %h ins %h", i, obs_word(), m_prev, ins);
            end
            n_tests++;
            if (int'(bus.o_bubble_count) != m_cnt) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, bus.o_bubble_count, m_cnt);
            end
        end
    endtask

    initial begin
        bus.i_instruction = '0;
        bus.i_valid       = 1'b0;
        bus.i_flush       = 1'b0;
        m_prev            = bubble(1'b0);
        m_halted          = 1'b0;
        m_cnt             = 0;
        test_reset();
        test_load_use();
        test_reset_mid_stall();
        test_no_dependency();
        test_dest_r0();
        test_flush();
        test_decode_table();
        test_counter_saturation();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
